// File: rtl/button_count_fifo.sv
// Button press counter feeding a DEPTH-entry shift FIFO. Each press increments
// the count. While logging is enabled, the new count is also pushed into the FIFO.
module button_count_fifo #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*CNT_W-1:0] concatenated_out,
  output logic                   empty,
  output logic                   full
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // Two-stage registered button: btn_r is the sampled level, btn_rr its past.
  logic             btn_r_q,  btn_r_d;
  logic             btn_rr_q, btn_rr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [LVL_W-1:0] lvl_q,    lvl_d;
  logic [CNT_W-1:0] slot_q [DEPTH];
  logic [CNT_W-1:0] slot_d [DEPTH];

  logic             press;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_inc;
  logic [LVL_W-1:0] wr_idx;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LVL_FULL);

  always_comb begin
    btn_r_d   = btn;
    btn_rr_d  = btn_r_q;
    press     = btn_r_q & ~btn_rr_q;
    count_inc = count_q + CNT_W'(1);
    count_d   = press ? count_inc : count_q;
    push      = press & wr_en;
    pop       = rd_en & ~empty;
  end

  // A pop shifts everything down first, so a simultaneous push lands one
  // slot lower than it would alone; this is what lets a full FIFO accept it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
    end
    lvl_d  = lvl_q;
    wr_idx = pop ? (lvl_q - LVL_W'(1)) : lvl_q;

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i + 1];
      end
      slot_d[DEPTH-1] = '0;
    end

    if (push && (pop || !full)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (LVL_W'(i) == wr_idx) begin
          slot_d[i] = count_inc;
        end
      end
      if (!pop) begin
        lvl_d = lvl_q + LVL_W'(1);
      end
    end else if (pop) begin
      lvl_d = lvl_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_r_q  <= 1'b0;
      btn_rr_q <= 1'b0;
      count_q  <= '0;
      lvl_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      btn_r_q  <= btn_r_d;
      btn_rr_q <= btn_rr_d;
      count_q  <= count_d;
      lvl_q    <= lvl_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    concatenated_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      concatenated_out[i*CNT_W +: CNT_W] = slot_q[i];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_button_count_fifo.sv
// Randomized and directed bench for button_count_fifo. A queue-based reference
// model predicts every post-edge output, and a monitor checks each prediction.
module tb_button_count_fifo;

  logic        clk;
  logic        rst;
  logic        btn;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  count;
  logic [31:0] concatenated_out;
  logic        empty;
  logic        full;

  button_count_fifo #(.CNT_W(8), .DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .btn              (btn),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .count            (count),
    .concatenated_out (concatenated_out),
    .empty            (empty),
    .full             (full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected entry: {count, concatenated_out, empty, full}
  logic [41:0] exp_q[$];

  // reference model state
  int m_fifo[$];
  int m_cnt = 0;
  bit m_b1  = 0;
  bit m_b2  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] model_word();
    logic [31:0] cat;
    cat = '0;
    for (int i = 0; i < m_fifo.size(); i++) begin
      cat[i*8 +: 8] = 8'(m_fifo[i]);
    end
    return {8'(m_cnt), cat, m_fifo.size() == 0, m_fifo.size() == 4};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_cnt = 0;
    m_b1  = 0;
    m_b2  = 0;
  endtask

  // driver: one call = one rising edge with these inputs
  task automatic step(input bit b, input bit w, input bit r);
    bit press;
    @(negedge clk);
    btn   = b;
    wr_en = w;
    rd_en = r;
    press = m_b1 && !m_b2;
    m_b2  = m_b1;
    m_b1  = b;
    if (press) m_cnt = (m_cnt + 1) % 256;
    if (r && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (press && w && m_fifo.size() < 4) m_fifo.push_back(m_cnt);
    exp_q.push_back(model_word());
  endtask

  // btn goes high for 'hold' edges then low for 2; rd on the press edge if asked
  task automatic press_btn(input bit w, input int hold, input bit rd_on_press);
    step(1, w, 0);
    for (int i = 1; i < hold; i++) step(1, w, 0);
    step(0, w, (hold == 1) ? rd_on_press : 1'b0);
    step(0, w, 0);
  endtask

  task automatic check_now(input string name, input logic [7:0] c,
                           input logic [31:0] cat, input bit e, input bit f);
    @(posedge clk);
    #1;
    chk({name, "_count"}, 32'(count), 32'(c));
    chk({name, "_cat"}, concatenated_out, cat);
    chk({name, "_empty"}, 32'(empty), 32'(e));
    chk({name, "_full"}, 32'(full), 32'(f));
  endtask

  // asynchronous reset mid-cycle, checked before any clock edge
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_cat", concatenated_out, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    @(negedge clk);
    btn   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;
    model_reset();
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [41:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_count", 32'(count), 32'(e[41:34]));
      chk("mon_cat", concatenated_out, e[33:2]);
      chk("mon_empty", 32'(empty), 32'(e[1]));
      chk("mon_full", 32'(full), 32'(e[0]));
    end
  end

  initial begin
    btn   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    #1;
    chk("init_count", 32'(count), 32'd0);
    chk("init_cat", concatenated_out, 32'd0);
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_full", 32'(full), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // four logged presses fill the FIFO
    for (int i = 0; i < 4; i++) press_btn(1, 3, 0);
    check_now("fill4", 8'd4, 32'h04030201, 0, 1);

    // long hold while full: one increment, push dropped
    press_btn(1, 20, 0);
    check_now("hold_full", 8'd5, 32'h04030201, 0, 1);

    step(0, 0, 1);
    check_now("pop1", 8'd5, 32'h00040302, 0, 0);

    for (int i = 0; i < 5; i++) step(0, 0, 1);
    check_now("underflow", 8'd5, 32'h0, 1, 0);

    press_btn(0, 2, 0);
    check_now("nolog", 8'd6, 32'h0, 1, 0);

    // press and pop on the same edge while empty: only the push happens
    press_btn(1, 1, 1);
    check_now("empty_pushpop", 8'd7, 32'h00000007, 0, 0);

    async_reset();

    // wrap: 252 unlogged presses, then 4 logged ones crossing 255 -> 0
    for (int i = 0; i < 252; i++) press_btn(0, 1, 0);
    for (int i = 0; i < 4; i++) press_btn(1, 1, 0);
    check_now("wrap", 8'd0, 32'h00FFFEFD, 0, 1);

    // full with press and pop on the same edge
    press_btn(1, 1, 1);
    check_now("full_pushpop", 8'd1, 32'h0100FFFE, 0, 1);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0));
      end
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
